// File: rtl/div_pkg.sv
// Shared constants for the divider peripheral: register map, CTRL/STATUS
// bit positions and the sequencer state encoding.
package div_pkg;

  localparam logic [2:0] ADDR_DV     = 3'd0;
  localparam logic [2:0] ADDR_DR     = 3'd1;
  localparam logic [2:0] ADDR_CTRL   = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_QUOT   = 3'd4;
  localparam logic [2:0] ADDR_REM    = 3'd5;
  localparam logic [2:0] ADDR_CLR    = 3'd6;

  localparam int CTRL_START  = 0;
  localparam int CTRL_SIGNED = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_DIV0 = 2;

  // Iteration counter is wide enough for WIDTH up to 32.
  localparam int CNT_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_RUN,
    ST_FIX,
    ST_DONE
  } div_state_e;

endpackage

// File: rtl/div_seq_core.sv
// Sequential restoring divider: one quotient bit per cycle, with sign
// handling around an unsigned magnitude core.
module div_seq_core
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dv,
  input  logic [WIDTH-1:0] dr,
  output logic             busy,
  output logic             done_pulse,
  output logic             div0,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] dv_q, dv_d, dr_q, dr_d, dvsr_q, dvsr_d;
  logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sign_q, sign_d, div0_q, div0_d;
  logic [WIDTH:0]   r_shift, r_diff;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      dv_q    <= '0;
      dr_q    <= '0;
      dvsr_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dv_q    <= dv_d;
      dr_q    <= dr_d;
      dvsr_q  <= dvsr_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      div0_q  <= div0_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dv_d       = dv_q;
    dr_d       = dr_q;
    dvsr_d     = dvsr_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    sign_d     = sign_q;
    div0_d     = div0_q;
    done_pulse = 1'b0;
    // The dividend shifts out of quot_q's top bit into the partial remainder.
    r_shift    = {rem_q, quot_q[WIDTH-1]};
    r_diff     = r_shift - {1'b0, dvsr_q};
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dv_d    = dv;
          dr_d    = dr;
          sign_d  = signed_mode;
          div0_d  = 1'b0;
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        div0_d  = (dr_q == '0);
        quot_d  = (sign_q && dv_q[WIDTH-1]) ? -dv_q : dv_q;
        dvsr_d  = (sign_q && dr_q[WIDTH-1]) ? -dr_q : dr_q;
        rem_d   = '0;
        cnt_d   = '0;
        // Divide-by-zero skips the iterations; FIX substitutes the fixed result.
        state_d = (dr_q == '0) ? ST_FIX : ST_RUN;
      end
      ST_RUN: begin
        if (!r_diff[WIDTH]) begin
          rem_d  = r_diff[WIDTH-1:0];
          quot_d = {quot_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d  = r_shift[WIDTH-1:0];
          quot_d = {quot_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (div0_q) begin
          quot_d = '1;
          rem_d  = dv_q;
        end else begin
          if (sign_q && (dv_q[WIDTH-1] ^ dr_q[WIDTH-1])) quot_d = -quot_q;
          if (sign_q && dv_q[WIDTH-1]) rem_d = -rem_q;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done_pulse = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);
  assign div0 = div0_q;
  assign quot = quot_q;
  assign rem  = rem_q;

endmodule

// File: rtl/peripheral_div_param.sv
// Bus-mapped divider peripheral: register decode, result/status registers
// and interrupt around the div_seq_core sequencer.
module peripheral_div_param
  import div_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1,
  parameter int clk_freq  = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d_in,
  input  logic        cs,
  input  logic [4:2]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [31:0] d_out,
  output logic        irq
);

  if (WIDTH < 8 || WIDTH > 32 || clk_freq <= 0) begin : g_param_check
    $error("peripheral_div_param: unsupported parameter value");
  end

  logic [WIDTH-1:0] dv_q, dv_d, dr_q, dr_d, quot_q, quot_d, rem_q, rem_d;
  logic             signed_q, signed_d, irq_en_q, irq_en_d, done_q, done_d;
  logic             div0_q, div0_d, op_signed_q, op_signed_d, res_signed_q, res_signed_d;
  logic [31:0]      d_out_q, d_out_d, rd_data;
  logic             wr_en, start, start_signed;
  logic             core_busy, core_done, core_div0;
  logic [WIDTH-1:0] core_quot, core_rem;

  function automatic logic [31:0] extend(input logic [WIDTH-1:0] v, input logic sgn);
    return sgn ? 32'(signed'(v)) : 32'(v);
  endfunction

  div_seq_core #(.WIDTH(WIDTH)) u_core (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_mode(start_signed),
    .dv         (dv_q),
    .dr         (dr_q),
    .busy       (core_busy),
    .done_pulse (core_done),
    .div0       (core_div0),
    .quot       (core_quot),
    .rem        (core_rem)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dv_q         <= '0;
      dr_q         <= '0;
      quot_q       <= '0;
      rem_q        <= '0;
      signed_q     <= 1'b0;
      irq_en_q     <= 1'b0;
      done_q       <= 1'b0;
      div0_q       <= 1'b0;
      op_signed_q  <= 1'b0;
      res_signed_q <= 1'b0;
      d_out_q      <= '0;
    end else begin
      dv_q         <= dv_d;
      dr_q         <= dr_d;
      quot_q       <= quot_d;
      rem_q        <= rem_d;
      signed_q     <= signed_d;
      irq_en_q     <= irq_en_d;
      done_q       <= done_d;
      div0_q       <= div0_d;
      op_signed_q  <= op_signed_d;
      res_signed_q <= res_signed_d;
      d_out_q      <= d_out_d;
    end
  end

  always_comb begin
    wr_en        = cs & wr;
    start        = wr_en && (addr == ADDR_CTRL) && d_in[CTRL_START] && !core_busy;
    start_signed = SIGNED_EN & d_in[CTRL_SIGNED];
    dv_d         = dv_q;
    dr_d         = dr_q;
    quot_d       = quot_q;
    rem_d        = rem_q;
    signed_d     = signed_q;
    irq_en_d     = irq_en_q;
    done_d       = done_q;
    div0_d       = div0_q;
    op_signed_d  = op_signed_q;
    res_signed_d = res_signed_q;
    if (wr_en) begin
      case (addr)
        ADDR_DV: dv_d = d_in[WIDTH-1:0];
        ADDR_DR: dr_d = d_in[WIDTH-1:0];
        ADDR_CTRL: begin
          signed_d = start_signed;
          irq_en_d = d_in[CTRL_IRQ_EN];
        end
        ADDR_CLR: begin
          if (d_in[0]) begin
            done_d = 1'b0;
            div0_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
    if (start) begin
      done_d      = 1'b0;
      div0_d      = 1'b0;
      op_signed_d = start_signed;
    end
    // Completion is checked last so it wins over a same-cycle CLR.
    if (core_done) begin
      done_d       = 1'b1;
      div0_d       = core_div0;
      quot_d       = core_quot;
      rem_d        = core_rem;
      res_signed_d = op_signed_q;
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      ADDR_STATUS: begin
        rd_data[STAT_BUSY] = core_busy;
        rd_data[STAT_DONE] = done_q;
        rd_data[STAT_DIV0] = div0_q;
      end
      ADDR_QUOT: rd_data = extend(quot_q, res_signed_q);
      ADDR_REM:  rd_data = extend(rem_q, res_signed_q);
      default:   rd_data = '0;
    endcase
    d_out_d = (cs & rd) ? rd_data : 32'h0;
  end

  assign d_out = d_out_q;
  assign irq   = done_q & irq_en_q;

endmodule

// File: tb/tb_peripheral_div_param.sv
// Directed bench for peripheral_div_param: register access, result values,
// completion timing, divide-by-zero, overflow and reset abort.
module tb_peripheral_div_param;

  localparam logic [2:0] A_DV = 3'd0, A_DR = 3'd1, A_CTRL = 3'd2, A_STATUS = 3'd3;
  localparam logic [2:0] A_QUOT = 3'd4, A_REM = 3'd5, A_CLR = 3'd6, A_RSVD = 3'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] d_in = '0;
  logic        cs = 1'b0;
  logic [2:0]  addr = '0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] d_out;
  logic        irq;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  logic [31:0] rdata;

  peripheral_div_param dut (
    .clk  (clk),
    .rst  (rst),
    .d_in (d_in),
    .cs   (cs),
    .addr (addr),
    .rd   (rd),
    .wr   (wr),
    .d_out(d_out),
    .irq  (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [31:0] data);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; addr = a; d_in = data;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0; d_in = '0;
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [31:0] data);
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; addr = a;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
    data = d_out;
  endtask

  task automatic start_op(input logic [31:0] ctrl);
    write_reg(A_CTRL, ctrl);
    start_cyc = cyc;
  endtask

  task automatic wait_cycle(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input string tag);
    logic [31:0] s;
    int n;
    s = '0;
    n = 0;
    while (!s[1] && n < 100) begin
      read_reg(A_STATUS, s);
      n++;
    end
    checkOutput(tag, {31'b0, s[1]}, 32'd1);
  endtask

  task automatic check_reg(input string tag, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] v;
    read_reg(a, v);
    checkOutput(tag, v, exp);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;

    check_reg("reset_status", A_STATUS, 32'h0);
    check_reg("reset_quot", A_QUOT, 32'h0);
    check_reg("reset_rem", A_REM, 32'h0);
    checkOutput("reset_irq", {31'b0, irq}, 32'd0);
    check_reg("reserved_read", A_RSVD, 32'h0);
    @(negedge clk);
    checkOutput("dout_idle_zero", d_out, 32'h0);

    // Unsigned 100/7 with interrupt enabled, done at start+35
    write_reg(A_DV, 32'd100);
    write_reg(A_DR, 32'd7);
    start_op(32'b101);
    @(posedge clk); #1;
    checkOutput("u_busy_irq_low", {31'b0, irq}, 32'd0);
    wait_cycle(start_cyc + 34);
    checkOutput("u_irq_before", {31'b0, irq}, 32'd0);
    wait_cycle(start_cyc + 35);
    checkOutput("u_irq_at_done", {31'b0, irq}, 32'd1);
    check_reg("u_quot", A_QUOT, 32'd14);
    check_reg("u_rem", A_REM, 32'd2);
    check_reg("u_status", A_STATUS, 32'b010);

    write_reg(A_CLR, 32'h1);
    check_reg("clr_status", A_STATUS, 32'h0);
    checkOutput("clr_irq", {31'b0, irq}, 32'd0);

    // Signed -7/2 without interrupt
    write_reg(A_DV, 32'hFFFF_FFF9);
    write_reg(A_DR, 32'd2);
    start_op(32'b011);
    wait_done("s_done");
    check_reg("s_quot", A_QUOT, 32'hFFFF_FFFD);
    check_reg("s_rem", A_REM, 32'hFFFF_FFFF);
    checkOutput("s_irq_disabled", {31'b0, irq}, 32'd0);

    // Divide by zero, done at start+3
    write_reg(A_DV, 32'd5);
    write_reg(A_DR, 32'd0);
    start_op(32'b101);
    wait_cycle(start_cyc + 2);
    checkOutput("z_irq_before", {31'b0, irq}, 32'd0);
    wait_cycle(start_cyc + 3);
    checkOutput("z_irq_at_done", {31'b0, irq}, 32'd1);
    check_reg("z_quot", A_QUOT, 32'hFFFF_FFFF);
    check_reg("z_rem", A_REM, 32'd5);
    check_reg("z_status", A_STATUS, 32'b110);

    // Signed overflow -2^31 / -1
    write_reg(A_DV, 32'h8000_0000);
    write_reg(A_DR, 32'hFFFF_FFFF);
    start_op(32'b011);
    wait_done("o_done");
    check_reg("o_quot", A_QUOT, 32'h8000_0000);
    check_reg("o_rem", A_REM, 32'h0);
    check_reg("o_status", A_STATUS, 32'b010);

    // Running op ignores DV writes and a second start
    write_reg(A_DV, 32'd100);
    write_reg(A_DR, 32'd7);
    start_op(32'b101);
    wait_cycle(start_cyc + 8);
    write_reg(A_DV, 32'd50);
    write_reg(A_CTRL, 32'b101);
    check_reg("busy_old_quot", A_QUOT, 32'h8000_0000);
    wait_cycle(start_cyc + 34);
    checkOutput("b_irq_before", {31'b0, irq}, 32'd0);
    wait_cycle(start_cyc + 35);
    checkOutput("b_irq_at_done", {31'b0, irq}, 32'd1);
    check_reg("b_quot", A_QUOT, 32'd14);
    check_reg("b_rem", A_REM, 32'd2);

    // Reset mid-operation, then a fresh 9/3
    write_reg(A_DV, 32'd100);
    start_op(32'b101);
    wait_cycle(start_cyc + 12);
    rst = 1'b0;
    #1;
    checkOutput("r_irq_in_reset", {31'b0, irq}, 32'd0);
    checkOutput("r_dout_in_reset", d_out, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    check_reg("r_status", A_STATUS, 32'h0);
    check_reg("r_quot", A_QUOT, 32'h0);
    write_reg(A_DV, 32'd9);
    write_reg(A_DR, 32'd3);
    start_op(32'b001);
    wait_done("r_done");
    check_reg("r_new_quot", A_QUOT, 32'd3);
    check_reg("r_new_rem", A_REM, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
